// File: rtl/score_bcd_sched.sv
// Shares one shift-add-3 binary-to-BCD converter between the current and
// high score. Ports: clk, rst, curr_score, high_score, score_sw in;
// curr_bcd, high_bcd, disp_bcd, curr_ovf, high_ovf, busy, done out.
module score_bcd_sched #(
  parameter int SCORE_W = 16,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SCORE_W-1:0]    curr_score,
  input  logic [SCORE_W-1:0]    high_score,
  input  logic                  score_sw,
  output logic [4*DIGITS-1:0]   curr_bcd,
  output logic [4*DIGITS-1:0]   high_bcd,
  output logic [4*DIGITS-1:0]   disp_bcd,
  output logic                  curr_ovf,
  output logic                  high_ovf,
  output logic                  busy,
  output logic                  done
);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned CLAMP = pow10(DIGITS) - 1;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(SCORE_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  logic [SCORE_W-1:0] curr_last;
  logic [SCORE_W-1:0] high_last;
  logic [SCORE_W-1:0] bin;
  logic [BW-1:0]      acc;
  logic [CW-1:0]      cnt;
  logic               src;
  logic               ovf_pend;

  logic               req_c;
  logic               req_h;
  logic               grant_h;
  logic [SCORE_W-1:0] op;
  logic               op_ovf;
  logic [SCORE_W-1:0] clamped;
  logic [BW-1:0]      adj;

  always_comb begin
    req_c   = (curr_score != curr_last);
    req_h   = (high_score != high_last);
    // score_sw picks the winner only when both sources want service
    grant_h = req_h && (score_sw || !req_c);
    op      = grant_h ? high_score : curr_score;
    op_ovf  = 64'(op) > CLAMP;
    clamped = op_ovf ? SCORE_W'(CLAMP) : op;
    adj     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5)
                    ? acc[4*i +: 4] + 4'd3
                    : acc[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      curr_last <= '0;
      high_last <= '0;
      bin       <= '0;
      acc       <= '0;
      cnt       <= '0;
      src       <= 1'b0;
      ovf_pend  <= 1'b0;
      curr_bcd  <= '0;
      high_bcd  <= '0;
      curr_ovf  <= 1'b0;
      high_ovf  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_c || req_h) begin
            if (grant_h) high_last <= high_score;
            else         curr_last <= curr_score;
            src      <= grant_h;
            bin      <= clamped;
            ovf_pend <= op_ovf;
            acc      <= '0;
            cnt      <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= {adj[BW-2:0], bin[SCORE_W-1]};
          bin <= {bin[SCORE_W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(SCORE_W - 1)) state <= DONE;
        end
        DONE: begin
          if (src) begin
            high_bcd <= acc;
            high_ovf <= ovf_pend;
          end else begin
            curr_bcd <= acc;
            curr_ovf <= ovf_pend;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign disp_bcd = score_sw ? high_bcd : curr_bcd;

endmodule
